// File: rtl/piradip_trigger_pkg.sv
// Shared types and constants for the piradip trigger sequencer.
// Optional feature macro (consumed by the top): PIRADIP_TRIGGER_SEQUENCER_TIMESTAMP_EN.
package piradip_trigger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    COUNT,
    HOLD,
    DONE_WAIT
  } trig_seq_state_t;

  // Shortest arm spacing that still lets the bank's armed status be seen before the next expiry
  localparam int unsigned MIN_TRIGGER_PERIOD = 2;

  // Register map for a future AXI-lite wrapper
  localparam int unsigned REGISTER_SEQ_CTRL   = 32'h0000_0000;
  localparam int unsigned REGISTER_SEQ_PERIOD = 32'h0000_0004;
  localparam int unsigned REGISTER_SEQ_REPEAT = 32'h0000_0008;
  localparam int unsigned REGISTER_SEQ_STATUS = 32'h0000_000C;

endpackage

// File: rtl/piradip_period_timer.sv
// Loadable down-counter: load wins over enable, stops at zero, zero_c flags count==0.
module piradip_period_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/piradip_trigger_sequencer.sv
// Autonomous burst/periodic arm-pulse sequencer for a bank of piradip_single_trigger units.
// Optional: define PIRADIP_TRIGGER_SEQUENCER_TIMESTAMP_EN to add the last_arm_ts output.
module piradip_trigger_sequencer
  import piradip_trigger_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned N_TRIGGER = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] repeat_count,
  input  logic [N_TRIGGER-1:0] unit_armed,
  output logic                 arm,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] fire_count,
  output logic                 overrun
`ifdef PIRADIP_TRIGGER_SEQUENCER_TIMESTAMP_EN
  ,
  output logic [CNT_WIDTH-1:0] last_arm_ts
`endif
);

  localparam logic [CNT_WIDTH-1:0] MIN_PERIOD = CNT_WIDTH'(MIN_TRIGGER_PERIOD);
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

  trig_seq_state_t      state, state_d;
  logic [CNT_WIDTH-1:0] eff_period_q, eff_period_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                 finite_q, finite_d;
  logic [CNT_WIDTH-1:0] fire_count_d;
  logic                 overrun_d, done_d, arm_d, busy_d;
  logic                 tmr_load, tmr_en, tmr_zero_c;
  logic                 any_armed_c;

  assign any_armed_c = |unit_armed;

  piradip_period_timer #(
    .WIDTH (CNT_WIDTH)
  ) u_period_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (eff_period_q - MIN_PERIOD),
    .zero_c   (tmr_zero_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      eff_period_q <= '0;
      remaining_q  <= '0;
      finite_q     <= 1'b0;
      fire_count   <= '0;
      overrun      <= 1'b0;
      done         <= 1'b0;
      arm          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      eff_period_q <= eff_period_d;
      remaining_q  <= remaining_d;
      finite_q     <= finite_d;
      fire_count   <= fire_count_d;
      overrun      <= overrun_d;
      done         <= done_d;
      arm          <= arm_d;
      busy         <= busy_d;
    end
  end

  always_comb begin
    state_d      = state;
    eff_period_d = eff_period_q;
    remaining_d  = remaining_q;
    finite_d     = finite_q;
    fire_count_d = fire_count;
    overrun_d    = overrun;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          eff_period_d = (period < MIN_PERIOD) ? MIN_PERIOD : period;
          remaining_d  = repeat_count;
          finite_d     = (repeat_count != '0);
          fire_count_d = '0;
          overrun_d    = 1'b0;
          state_d      = ARM;
        end
      end
      ARM: begin
        fire_count_d = (fire_count == '1) ? fire_count : fire_count + ONE;
        tmr_load     = 1'b1;
        if (finite_q) begin
          remaining_d = remaining_q - ONE;
        end
        state_d = (finite_q && (remaining_q == ONE)) ? DONE_WAIT : COUNT;
      end
      COUNT: begin
        tmr_en = 1'b1;
        if (tmr_zero_c) begin
          if (any_armed_c) begin
            overrun_d = 1'b1;
            state_d   = HOLD;
          end else begin
            state_d = ARM;
          end
        end
      end
      HOLD: begin
        if (!any_armed_c) begin
          state_d = ARM;
        end
      end
      DONE_WAIT: begin
        if (!any_armed_c) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort takes priority over any pending arm or completion
    if (stop && (state != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end

    arm_d  = (state_d == ARM);
    busy_d = (state_d != IDLE);
  end

`ifdef PIRADIP_TRIGGER_SEQUENCER_TIMESTAMP_EN
  logic [CNT_WIDTH-1:0] ts_cnt;

  // Free-running cycle counter, sampled once per arm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt      <= '0;
      last_arm_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + ONE;
      if (state == ARM) begin
        last_arm_ts <= ts_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_piradip_trigger_sequencer.sv
// Directed self-checking bench for piradip_trigger_sequencer.
// Define PIRADIP_TRIGGER_SEQUENCER_TIMESTAMP_EN to also cover last_arm_ts.
module tb_piradip_trigger_sequencer;

  localparam int unsigned CW = 32;
  localparam int unsigned NT = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic [CW-1:0] period;
  logic [CW-1:0] repeat_count;
  logic [NT-1:0] unit_armed;
  logic          arm;
  logic          busy;
  logic          done;
  logic [CW-1:0] fire_count;
  logic          overrun;
`ifdef PIRADIP_TRIGGER_SEQUENCER_TIMESTAMP_EN
  logic [CW-1:0] last_arm_ts;
  logic [CW-1:0] ts1;
`endif

  piradip_trigger_sequencer #(
    .CNT_WIDTH (CW),
    .N_TRIGGER (NT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .period       (period),
    .repeat_count (repeat_count),
    .unit_armed   (unit_armed),
    .arm          (arm),
    .busy         (busy),
    .done         (done),
    .fire_count   (fire_count),
    .overrun      (overrun)
`ifdef PIRADIP_TRIGGER_SEQUENCER_TIMESTAMP_EN
    ,
    .last_arm_ts  (last_arm_ts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Arm/done event log, sampled mid-cycle
  int ncyc = 0;
  int arm_cnt = 0;
  int done_cnt = 0;
  int done_t = 0;
  int arm_t [256];

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (arm) begin
      arm_t[arm_cnt] = ncyc;
      arm_cnt = arm_cnt + 1;
    end
    if (done) begin
      done_t = ncyc;
      done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt = vec_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the mid-cycle where the first arm must be visible
  task automatic kick(input string tag, input int p, input int r);
    @(negedge clk);
    period       = CW'(p);
    repeat_count = CW'(r);
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_first_arm"}, 64'(arm), 64'(1));
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    for (int k = 0; k < budget && done_cnt == d0; k++) @(posedge clk);
    check({tag, "_done"}, 64'(done_cnt - d0), 64'(1));
    @(negedge clk);
  endtask

  int base, d0;

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    period       = '0;
    repeat_count = '0;
    unit_armed   = '0;
    repeat (3) @(negedge clk);
    check("rst_arm", 64'(arm), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_fire", 64'(fire_count), 64'(0));
    check("rst_ovr", 64'(overrun), 64'(0));
    rst = 1'b0;

    // period 10, three arms
    base = arm_cnt; d0 = done_cnt;
    kick("p10", 10, 3);
    wait_done("p10", d0, 200);
    check("p10_arms", 64'(arm_cnt - base), 64'(3));
    check("p10_gap1", 64'(arm_t[base+1] - arm_t[base]), 64'(10));
    check("p10_gap2", 64'(arm_t[base+2] - arm_t[base+1]), 64'(10));
    check("p10_done_lat", 64'(done_t - arm_t[base+2]), 64'(2));
    check("p10_fire", 64'(fire_count), 64'(3));
    check("p10_ovr", 64'(overrun), 64'(0));
    check("p10_busy", 64'(busy), 64'(0));

    // periods below the minimum clamp to 2
    for (int p = 0; p < 2; p++) begin
      base = arm_cnt; d0 = done_cnt;
      kick("pmin", p, 4);
      wait_done("pmin", d0, 100);
      check("pmin_arms", 64'(arm_cnt - base), 64'(4));
      check("pmin_gap1", 64'(arm_t[base+1] - arm_t[base]), 64'(2));
      check("pmin_gap3", 64'(arm_t[base+3] - arm_t[base+2]), 64'(2));
      check("pmin_fire", 64'(fire_count), 64'(4));
    end

    // continuous run aborted by stop after the 7th arm
    base = arm_cnt; d0 = done_cnt;
    kick("cont", 5, 0);
    for (int k = 0; k < 200 && (arm_cnt - base) < 7; k++) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    check("cont_busy_drop", 64'(busy), 64'(0));
    repeat (20) @(negedge clk);
    check("cont_arms", 64'(arm_cnt - base), 64'(7));
    check("cont_gap", 64'(arm_t[base+6] - arm_t[base+5]), 64'(5));
    check("cont_fire", 64'(fire_count), 64'(7));
    check("cont_no_done", 64'(done_cnt - d0), 64'(0));

    // overrun: bank stays armed past the first expiry
    base = arm_cnt; d0 = done_cnt;
    kick("ovr", 4, 3);
    unit_armed = NT'(32'h8);
    repeat (10) @(negedge clk);
    unit_armed = '0;
    wait_done("ovr", d0, 100);
    check("ovr_flag", 64'(overrun), 64'(1));
    check("ovr_arms", 64'(arm_cnt - base), 64'(3));
    check("ovr_gap1", 64'(arm_t[base+1] - arm_t[base]), 64'(11));
    check("ovr_gap2", 64'(arm_t[base+2] - arm_t[base+1]), 64'(4));
    check("ovr_fire", 64'(fire_count), 64'(3));

    // start and stop together from idle
    base = arm_cnt;
    @(negedge clk);
    period = CW'(3); repeat_count = CW'(2); start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 64'(busy), 64'(0));
    repeat (5) @(negedge clk);
    check("ss_arms", 64'(arm_cnt - base), 64'(0));
    check("ss_ovr_kept", 64'(overrun), 64'(1));

    // start while busy is ignored, as are input changes mid-run
    base = arm_cnt; d0 = done_cnt;
    kick("sb", 6, 2);
    repeat (2) @(negedge clk);
    period = CW'(3); repeat_count = CW'(9); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("sb", d0, 100);
    check("sb_arms", 64'(arm_cnt - base), 64'(2));
    check("sb_gap", 64'(arm_t[base+1] - arm_t[base]), 64'(6));
    check("sb_fire", 64'(fire_count), 64'(2));

    // reset mid-COUNT
    base = arm_cnt;
    kick("rmid", 20, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmid_busy", 64'(busy), 64'(0));
    check("rmid_fire", 64'(fire_count), 64'(0));
    check("rmid_arm", 64'(arm), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rmid_arms", 64'(arm_cnt - base), 64'(1));

`ifdef PIRADIP_TRIGGER_SEQUENCER_TIMESTAMP_EN
    d0 = done_cnt;
    kick("ts", 8, 2);
    @(negedge clk);
    ts1 = last_arm_ts;
    wait_done("ts", d0, 100);
    check("ts_delta", 64'(last_arm_ts - ts1), 64'(8));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/piradip_trigger_sequencer.md
Name: piradip_trigger_sequencer

Overview:
Controller that sequences arm pulses into a bank of piradip_single_trigger instances, or into the arm input of a trigger unit.
- Issues a programmable number of arm pulses at a fixed cycle period.
- Monitors the trigger bank's armed status, holds off re-arming while any channel is still counting, and flags overruns.
- Sits between the register/control plane and the trigger bank, replacing single software-written arms with autonomous burst/periodic triggering.

Parameters:
CNT_WIDTH, 32, width of period, repeat and fire counters
N_TRIGGER, 32, width of armed status vector from trigger bank

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins a run when idle
stop  in  1  single-cycle pulse; aborts a run
period  in  CNT_WIDTH  cycles between successive arm pulses; latched at start
repeat_count  in  CNT_WIDTH  number of arm pulses per run; 0 = continuous until stop; latched at start
unit_armed  in  N_TRIGGER  armed vector from trigger bank
arm  out  1  single-cycle arm pulse to trigger bank
busy  out  1  high while state != IDLE
done  out  1  single-cycle pulse when a finite run completes
fire_count  out  CNT_WIDTH  arm pulses issued in current/last run, saturating
overrun  out  1  sticky; period expired while any unit_armed bit high

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous, active-high.
- Reset values: arm=0, busy=0, done=0, fire_count=0, overrun=0, state=IDLE, internal counters=0.
- All outputs are registered (Moore); arm is high exactly in state ARM.
- Effective period: eff_period = max(period, 2). The minimum of 2 guarantees unit_armed is observable before the next expiry check.
- States:
  - IDLE: on start, latch eff_period and repeat_count, clear fire_count and overrun, go to ARM.
  - ARM (1 cycle): arm=1, fire_count+1 (saturating at all-ones), remaining-1 if finite, load timer=eff_period-2. Next state: if finite and remaining reaches 0 -> DONE_WAIT, else COUNT.
  - COUNT: timer decrements each cycle. At timer==0:
    - if |unit_armed, set overrun and go to HOLD;
    - else go to ARM.
  - HOLD: wait until unit_armed==0, then go to ARM. The skipped slot is not replayed.
  - DONE_WAIT: wait until unit_armed==0 (last triggers fired), then done=1 for one cycle and go to IDLE.
- Timing: start sampled at edge t -> arm high in cycle t+1. Consecutive arms with no overrun are exactly eff_period cycles apart.
- repeat_count=1: exactly one arm pulse, then done after the bank clears.
- repeat_count=0: continuous; remaining is never decremented; done never pulses.
- stop in any non-IDLE state: next state IDLE, no further arm, no done.
  - stop wins over the transition into ARM in the same cycle.
  - fire_count and overrun are retained.
- start while busy: ignored. start and stop in the same cycle from IDLE: stop wins, stay IDLE.
- period and repeat_count changes mid-run: ignored until the next start.
- rst mid-run: immediate return to reset values; a partially asserted arm drops asynchronously.

Optional Feature:
Macro PIRADIP_TRIGGER_SEQUENCER_TIMESTAMP_EN.
- Defined:
  - adds a free-running CNT_WIDTH cycle counter (reset 0, wraps);
  - adds output last_arm_ts [CNT_WIDTH], which captures the counter value in each ARM cycle and holds it until the next arm (reset 0).
- Undefined: no counter and no port; behaviour otherwise identical.

Decomposition:
- Package piradip_trigger_pkg:
  - typedef enum trig_seq_state_t {IDLE, ARM, COUNT, HOLD, DONE_WAIT};
  - localparam MIN_TRIGGER_PERIOD = 2;
  - REGISTER_* offsets for a future AXI-lite wrapper: SEQ_CTRL, SEQ_PERIOD, SEQ_REPEAT, SEQ_STATUS.
- One natural sub-module: piradip_period_timer, a loadable down-counter with load, enable and zero flag, reused for COUNT.

Test Plan:
- period=10, repeat=3, unit_armed=0 -> arms at cycles t+1, t+11, t+21; done 1 cycle after DONE_WAIT entry; fire_count=3; overrun=0.
- period=0 and period=1 -> both behave as period=2: arms every 2 cycles, repeat=4 gives fire_count=4.
- period=5, repeat=0, stop asserted after 7th arm -> exactly 7 arms, busy drops next cycle, done never asserts, fire_count=7.
- period=4, repeat=3, unit_armed[3] held high for 10 cycles after first arm -> overrun=1; second arm delayed until unit_armed clears; total 3 arms; done after final clear.
- start and stop in the same cycle; start while busy -> no arm / run unaffected. rst pulsed mid-COUNT -> all outputs 0 immediately, no further arm.
- With PIRADIP_TRIGGER_SEQUENCER_TIMESTAMP_EN: period=8, repeat=2 -> successive last_arm_ts values differ by 8.
